// File: rtl/upsample2x_stream.sv
// upsample2x_stream
//
// Row-streaming 2x2 upsampler. Takes a DIM/2 x DIM/2 feature map one row per
// handshake and emits a DIM x DIM map one row per handshake. Each accepted
// input row is held in a single buffer and produces two output rows: TOP
// (even row 2r) and BOT (odd row 2r+1).
//
// Build option:
//   UPSAMPLE_UNPOOL_EN  defined   -> max-unpool. Each value goes to the one
//                                    position of its 2x2 block named by its
//                                    argmax code. The other three are zero.
//                       undefined -> nearest-neighbour replication.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   in_valid     input row valid
//   in_ready     block can accept an input row (combinational from out_ready)
//   in_row       input row, element j = column j
//   in_idx       argmax code per element, 0=TL 1=TR 2=BL 3=BR (unpool only)
//   out_valid    output row valid
//   out_ready    consumer accepts the output row
//   out_row      output row, DIM elements
//   out_row_num  index of the current output row, 0..DIM-1
//   out_last     high with out_valid on row DIM-1 (end of frame)

module upsample2x_stream #(
   parameter int BITS = 8,
   parameter int DIM  = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [DIM/2-1:0][BITS-1:0]     in_row,
`ifdef UPSAMPLE_UNPOOL_EN
   input  logic [DIM/2-1:0][1:0]          in_idx,
`endif
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [DIM-1:0][BITS-1:0]       out_row,
   output logic [$clog2(DIM)-1:0]         out_row_num,
   output logic                           out_last
);

   localparam int HALF = DIM / 2;
   localparam int RW   = (HALF > 1) ? $clog2(HALF) : 1;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      TOP   = 2'd1,
      BOT   = 2'd2
   } state_t;

   state_t                       state;
   logic [RW-1:0]                rowCnt;
   logic [HALF-1:0][BITS-1:0]    bufRow;
`ifdef UPSAMPLE_UNPOOL_EN
   logic [HALF-1:0][1:0]         bufIdx;
`endif

   logic isBot;

   assign isBot = (state == BOT);

   // Combinational ready lets BOT hand off and capture the next row in the
   // same cycle, which sustains one output row per cycle.
   assign in_ready = !rst && ((state == EMPTY) || (isBot && out_ready));

   // ---- state / buffer register ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= EMPTY;
         rowCnt <= '0;
         bufRow <= '0;
`ifdef UPSAMPLE_UNPOOL_EN
         bufIdx <= '0;
`endif
      end else begin
         case (state)
            EMPTY: begin
               if (in_valid) begin
                  bufRow <= in_row;
`ifdef UPSAMPLE_UNPOOL_EN
                  bufIdx <= in_idx;
`endif
                  state  <= TOP;
               end
            end
            TOP: begin
               if (out_ready) state <= BOT;
            end
            BOT: begin
               if (out_ready) begin
                  // HALF need not be a power of two, so wrap explicitly.
                  rowCnt <= (rowCnt == RW'(HALF - 1)) ? '0 : rowCnt + 1'b1;
                  if (in_valid) begin
                     bufRow <= in_row;
`ifdef UPSAMPLE_UNPOOL_EN
                     bufIdx <= in_idx;
`endif
                     state  <= TOP;
                  end else begin
                     state  <= EMPTY;
                  end
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

   // ---- output decode from registered state ----
   assign out_valid   = (state != EMPTY);
   assign out_row_num = {rowCnt, isBot};
   assign out_last    = out_valid && (out_row_num == ($clog2(DIM))'(DIM - 1));

   always_comb begin
      out_row = '0;
      if (out_valid) begin
         for (int j = 0; j < HALF; j++) begin
`ifdef UPSAMPLE_UNPOOL_EN
            // Code {bot,right} picks which of the four block positions gets v.
            if (bufIdx[j] == {isBot, 1'b0}) out_row[2*j]   = bufRow[j];
            if (bufIdx[j] == {isBot, 1'b1}) out_row[2*j+1] = bufRow[j];
`else
            out_row[2*j]   = bufRow[j];
            out_row[2*j+1] = bufRow[j];
`endif
         end
      end
   end

endmodule
